// File: rtl/uart_mon_pkg.sv
// Shared UART monitor definitions: ASCII constants and formatter state encodings.
package uart_mon_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0d;
  localparam logic [7:0] ASCII_LF   = 8'h0a;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h61;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ECHO,
    ST_HEX,
    ST_SEP,
    ST_CR,
    ST_LF
  } fmt_state_e;

endpackage

// File: rtl/nib2ascii.sv
// Combinational nibble to lowercase ASCII hex digit.
module nib2ascii
  import uart_mon_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nib < 4'd10) o_ascii = ASCII_ZERO + {4'h0, i_nib};
    else               o_ascii = ASCII_A + ({4'h0, i_nib} - 8'd10);
  end

endmodule

// File: rtl/uart_send_char.sv
// UART monitor TX formatter: echo, 32-bit hex words with separator, CR LF.
// Define UART_ECHO_EN to include the echo path.
module uart_send_char
  import uart_mon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        echo_en,
  input  logic [7:0]  echo_char,
  input  logic        crlf_in,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  fmt_state_e  r_state, w_next;
  logic [31:0] r_shift;
  logic [3:0]  r_cnt;
  logic        r_last;
  logic        r_crlf_pend;
  logic        w_xfer, w_accept;
  logic        w_echo_pend, w_echo_req;
  logic [7:0]  w_echo_byte, w_nib_ascii;

  assign w_xfer   = tx_valid & tx_ready;
  assign w_accept = word_valid & word_ready;

`ifdef UART_ECHO_EN
  logic       r_echo_pend;
  logic [7:0] r_echo_buf, r_echo_tx;

  assign w_echo_pend = r_echo_pend;
  assign w_echo_req  = echo_en;
  assign w_echo_byte = r_echo_tx;

  // The sent byte is latched separately so a new echo_en can refill the buffer mid-send.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_echo_pend <= 1'b0;
      r_echo_buf  <= '0;
      r_echo_tx   <= '0;
    end else if (r_state == ST_IDLE && w_next == ST_ECHO) begin
      r_echo_tx   <= echo_en ? echo_char : r_echo_buf;
      r_echo_pend <= 1'b0;
    end else if (echo_en) begin
      r_echo_buf  <= echo_char;
      r_echo_pend <= 1'b1;
    end
  end
`else
  logic w_unused_echo;
  assign w_unused_echo = ^{echo_en, echo_char};
  assign w_echo_pend   = 1'b0;
  assign w_echo_req    = 1'b0;
  assign w_echo_byte   = '0;
`endif

  nib2ascii u_nib2ascii (
    .i_nib   (r_shift[31:28]),
    .o_ascii (w_nib_ascii)
  );

  // Pending requests beat a new word; fresh pulses only start when no word is offered.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_echo_pend)      w_next = ST_ECHO;
        else if (r_crlf_pend) w_next = ST_CR;
        else if (w_accept)    w_next = ST_HEX;
        else if (w_echo_req)  w_next = ST_ECHO;
        else if (crlf_in)     w_next = ST_CR;
      end
      ST_ECHO: if (w_xfer) w_next = ST_IDLE;
      ST_HEX:  if (w_xfer && r_cnt == 4'd7) w_next = r_last ? ST_CR : ST_SEP;
      ST_SEP:  if (w_xfer) w_next = ST_IDLE;
      ST_CR:   if (w_xfer) w_next = ST_LF;
      ST_LF:   if (w_xfer) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_crlf_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_shift <= word_data;
        r_last  <= word_last;
        r_cnt   <= '0;
      end else if (r_state == ST_HEX && w_xfer) begin
        r_shift <= {r_shift[27:0], 4'h0};
        r_cnt   <= r_cnt + 4'd1;
      end
      // A CR LF leaving IDLE consumes the request; pulses during any other state queue one more.
      if (r_state == ST_IDLE && w_next == ST_CR) r_crlf_pend <= 1'b0;
      else if (crlf_in)                          r_crlf_pend <= 1'b1;
    end
  end

  always_comb begin
    tx_data = '0;
    case (r_state)
      ST_ECHO: tx_data = w_echo_byte;
      ST_HEX:  tx_data = w_nib_ascii;
      ST_SEP:  tx_data = ASCII_SP;
      ST_CR:   tx_data = ASCII_CR;
      ST_LF:   tx_data = ASCII_LF;
      default: tx_data = '0;
    endcase
  end

  assign tx_valid   = (r_state != ST_IDLE);
  assign busy       = tx_valid | w_echo_pend | r_crlf_pend;
  assign word_ready = (r_state == ST_IDLE) & ~w_echo_pend & ~r_crlf_pend & ~rst;

endmodule

// File: tb/tb_uart_send_char.sv
// Self-checking bench for uart_send_char: byte-queue model plus literal sequences.
module tb_uart_send_char;

  logic        clk = 1'b0;
  logic        rst;
  logic        echo_en;
  logic [7:0]  echo_char;
  logic        crlf_in;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int rmode    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic       hold = 1'b0;
  logic [7:0] hold_data = '0;

  uart_send_char dut (
    .clk        (clk),
    .rst        (rst),
    .echo_en    (echo_en),
    .echo_char  (echo_char),
    .crlf_in    (crlf_in),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_ready (word_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: the exact byte string the formatter owes for a word.
  task automatic push_word(input logic [31:0] d, input logic l);
    string s;
    s = $sformatf("%08h", d);
    for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
    if (l) begin
      exp_q.push_back(8'h0d);
      exp_q.push_back(8'h0a);
    end else begin
      exp_q.push_back(8'h20);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold <= 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", {31'b0, tx_valid}, 32'd1);
        check("hold_data", {24'b0, tx_data}, {24'b0, hold_data});
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        got_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL spurious_byte: got %0h expected none (cycle %0d)", tx_data, cyc);
        end else begin
          check("tx_byte", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
        end
      end
      hold      <= tx_valid & ~tx_ready;
      hold_data <= tx_data;
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b1;
      endcase
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l, output int acc);
    logic ok;
    ok = 1'b0;
    acc = -1;
    word_data = d; word_last = l; word_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (word_ready) ok = 1'b1;
    end
    check("word_accept", {31'b0, ok}, 32'd1);
    if (ok) begin
      push_word(d, l);
      acc = cyc;
    end
    @(posedge clk);
    #1;
    word_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !tx_valid) ok = 1'b1;
    end
    check({name, "_drain"}, {31'b0, ok}, 32'd1);
  endtask

  task automatic check_log(input string name, input logic [7:0] lit[$]);
    check({name, "_len"}, got_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < got_q.size(); i++)
      check({name, "_lit"}, {24'b0, got_q[i]}, {24'b0, lit[i]});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] lit[$];
    int acc;
    rst = 1'b1; echo_en = 1'b0; echo_char = '0; crlf_in = 1'b0;
    word_valid = 1'b0; word_data = '0; word_last = 1'b0;

    // Reset values
    @(negedge clk); @(negedge clk);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_word_ready", {31'b0, word_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    step; rst = 1'b0;
    @(negedge clk);
    check("idle_word_ready", {31'b0, word_ready}, 32'd1);

    // One word, space separator, full rate
    step; got_q.delete(); got_cyc.delete();
    send_word(32'h1234abcd, 1'b0, acc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("w1_word_ready", {31'b0, word_ready}, (i == 9) ? 32'd1 : 32'd0);
    end
    wait_quiet("w1");
    lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64, 8'h20};
    check_log("w1", lit);
    if (got_cyc.size() == 9) begin
      check("w1_first_cyc", got_cyc[0], acc + 1);
      check("w1_last_cyc", got_cyc[8], acc + 9);
    end

    // Last word with CR LF under alternating backpressure
    step; got_q.delete(); rmode = 1;
    send_word(32'hdeadbeef, 1'b1, acc);
    wait_quiet("w2");
    rmode = 0;
    lit = '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0d, 8'h0a};
    check_log("w2", lit);

    // CR LF pulses during a word collapse into one trailing CR LF
    step; got_q.delete();
    send_word(32'h0000ffff, 1'b0, acc);
    crlf_in = 1'b1; exp_q.push_back(8'h0d); exp_q.push_back(8'h0a);
    step; crlf_in = 1'b0;
    step; crlf_in = 1'b1;
    step;
    step; crlf_in = 1'b0;
    wait_quiet("w3");
    lit = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h66, 8'h66, 8'h66, 8'h66, 8'h20, 8'h0d, 8'h0a};
    check_log("w3", lit);

`ifdef UART_ECHO_EN
    // Echo beats CR LF in IDLE
    step; got_q.delete(); got_cyc.delete();
    echo_char = 8'h72; echo_en = 1'b1; crlf_in = 1'b1;
    exp_q.push_back(8'h72); exp_q.push_back(8'h0d); exp_q.push_back(8'h0a);
    acc = cyc;
    step; echo_en = 1'b0; crlf_in = 1'b0;
    wait_quiet("e1");
    lit = '{8'h72, 8'h0d, 8'h0a};
    check_log("e1", lit);
    if (got_cyc.size() > 0) check("e1_latency", got_cyc[0], acc + 1);

    // Second mid-word echo overwrites the first
    step; got_q.delete();
    send_word(32'h00000000, 1'b0, acc);
    echo_char = 8'h31; echo_en = 1'b1;
    step; echo_en = 1'b0;
    step; echo_char = 8'h32; echo_en = 1'b1;
    exp_q.push_back(8'h32);
    step; echo_en = 1'b0;
    wait_quiet("e2");
    lit = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h20, 8'h32};
    check_log("e2", lit);
`else
    // Echo compiled out: nothing sent, never busy
    step; got_q.delete();
    echo_char = 8'h77; echo_en = 1'b1;
    step; echo_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("noecho_busy", {31'b0, busy}, 32'd0);
      check("noecho_valid", {31'b0, tx_valid}, 32'd0);
    end
    check("noecho_bytes", got_q.size(), 32'd0);
`endif

    // Reset after the third digit discards the word
    step; got_q.delete();
    send_word(32'h12345678, 1'b0, acc);
    for (int k = 0; k < 50 && got_q.size() < 3; k++) @(negedge clk);
    check("r_third_digit", got_q.size(), 32'd3);
    step; rst = 1'b1; exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("r_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("r_busy", {31'b0, busy}, 32'd0);
    step; rst = 1'b0; got_q.delete();
    send_word(32'h00000000, 1'b0, acc);
    wait_quiet("r2");
    lit = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h20};
    check_log("r2", lit);

    // Random words under random backpressure, checked by the model only
    rmode = 2;
    for (int i = 0; i < 4; i++) begin
      step;
      send_word($urandom, 1'($urandom_range(0, 1)), acc);
    end
    wait_quiet("rnd");
    rmode = 0;

    step;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
